ysyx_25010008_axil_sram: RTL and testbench
==========================================

# ysyx_25010008_axil_sram

AXI4-Lite responder wrapping a word-addressed SRAM model with byte-strobe writes and configurable response latency. It is the slave end of the memory bus driven by the core's load/store unit and instruction fetch, and is used both as the simulation data memory and as the target the LSU handshake is verified against. One transaction is in flight at a time, read or write, with round-robin arbitration between the two channels.

## Interface
- ADDR_BASE, 32'h8000_0000, byte address of word 0
- DEPTH_WORDS, 4096, number of 32-bit words (power of two)
- RD_LATENCY, 1, cycles from AR handshake to rvalid rising (0..15)
- WR_LATENCY, 1, cycles from both AW and W captured to bvalid rising (0..15)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address accept
- rdata  out  32  read word, full 32 bits, no lane shifting
- rresp  out  2  00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data accept
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address accept
- wdata  in  32  write word, already lane-aligned by initiator
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data accept
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response accept

## Operation
- States: IDLE, R_WAIT, R_RESP, W_COLLECT, W_WAIT, B_RESP.
- IDLE arbitration: wr_sel = awvalid && (!arvalid || last_was_read). arready = IDLE && arvalid && !wr_sel. awready = wready = IDLE && wr_sel. last_was_read resets to 0 (read wins first tie).
- Read: on AR handshake latch address, load counter with RD_LATENCY, go R_WAIT; counter 0 -> R_RESP with rdata/rresp registered. R_RESP holds rvalid, rdata, rresp stable until rready; then IDLE, last_was_read=1.
- Write: in IDLE, AW and W accepted independently; each captured into a holding register with a got flag. If only one arrived, go W_COLLECT; in W_COLLECT only the missing channel's ready is high. Both captured -> load WR_LATENCY, W_WAIT; at 0 perform strobed write, enter B_RESP, hold bvalid/bresp until bready; then IDLE, last_was_read=0.
- Address decode: in range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS; index = (addr - ADDR_BASE)[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
- Out of range: read returns rdata=0, rresp=10; write modifies nothing, bresp=10.
- Strobe: byte i written iff wstrb[i]; wstrb=0 in range is OKAY with no change.
- Memory contents are not cleared by reset (undefined until written).

## Timing
- Reset (asynchronous assert, synchronous deassert handled by the reset synchronizer upstream): all outputs 0, state IDLE, counters 0, got flags 0. Reset mid-transaction abandons it: a pending write not yet in B_RESP performs no array update.
- Read latency with RD_LATENCY=L: rvalid rises L+1 cycles after the AR handshake edge.
- Write latency: bvalid rises WR_LATENCY+1 cycles after the edge capturing the later of AW/W; array update visible to a read issued the cycle after the B handshake.
- No new ready asserted while rvalid or bvalid is high; at most one outstanding transaction.
- Valid outputs never drop without the matching ready (AXI rule).

## Structure
- Shared package ysyx_25010008_axi_pkg: RESP_OKAY/RESP_SLVERR constants, state enum for this block.
- One sub-module ysyx_25010008_sram_array: synchronous-write, registered-read array with 4-bit byte enable; instantiated once.

## Test plan
- Write 0xDEADBEEF to 0x8000_0010 strobe 1111, read back -> rdata=0xDEADBEEF, rresp=00, bresp=00.
- Then write 0x0000_AB00 strobe 0010 to 0x8000_0010 -> read returns 0xDEADABEF.
- Read 0x7FFF_FFFC and write 0x8000_4000 (DEPTH 4096) -> rresp=10 rdata=0, bresp=10, 0x8000_0000 unchanged.
- arvalid and awvalid raised same cycle twice in a row after reset -> order read, write, read, write.
- rready held low 5 cycles after rvalid -> rvalid/rdata stable all 5 cycles, no arready during them.
- wvalid 3 cycles before awvalid, RD/WR_LATENCY=0 -> wready pulses once, awready on AW arrival, bvalid 1 cycle later; assert reset during W_WAIT in a repeat -> all outputs 0, word unchanged.

Source files
------------

// File: rtl/ysyx_25010008_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25010008_axi_pkg
// Shared AXI4-Lite definitions for the SRAM responder:
//   RESP_OKAY / RESP_SLVERR  - rresp/bresp encodings
//   axilState_t              - transaction FSM states of the responder
//   addrInRange()            - byte-address window check used by the decoder
// ---------------------------------------------------------------------------
package ysyx_25010008_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_WAIT,
    ST_R_RESP,
    ST_W_COLLECT,
    ST_W_WAIT,
    ST_B_RESP
  } axilState_t;

  // The offset is computed one bit wider so that an address below the base
  // cannot wrap around into the window.
  function automatic logic addrInRange(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] spanBytes);
    logic [32:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (offset < spanBytes);
  endfunction

endpackage

// File: rtl/ysyx_25010008_sram_array.sv
// ---------------------------------------------------------------------------
// ysyx_25010008_sram_array
// Word-organised SRAM model with synchronous byte-enabled write and a
// registered read port. Contents are never cleared.
//   i_clock          clock, rising edge
//   i_re / i_raddr   read enable and word index; data appears on o_rdata
//                    after the next rising edge and holds until the next read
//   i_we / i_waddr   write enable and word index
//   i_wdata/i_wstrb  write word and per-byte enables
// ---------------------------------------------------------------------------
module ysyx_25010008_sram_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clock,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_wstrb
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Byte-lane write: only lanes with their strobe set are touched, so a
  // partial store leaves the neighbouring bytes intact.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read: the word is sampled only when asked for, so the output
  // stays put for as long as the responder is presenting it.
  always_ff @(posedge i_clock) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_25010008_axil_sram.sv
// ---------------------------------------------------------------------------
// ysyx_25010008_axil_sram
// AXI4-Lite responder in front of a word-addressed SRAM. One transaction at
// a time; read and write requests arriving together are served round-robin.
// Parameters: ADDR_BASE (byte address of word 0), DEPTH_WORDS (power of two),
//             RD_LATENCY / WR_LATENCY (0..15 extra wait cycles).
// Ports:
//   i_clock, i_reset_n                 clock, async active-low reset
//   i_araddr/i_arvalid/o_arready       read address channel
//   o_rdata/o_rresp/o_rvalid/i_rready  read data channel
//   i_awaddr/i_awvalid/o_awready       write address channel
//   i_wdata/i_wstrb/i_wvalid/o_wready  write data channel
//   o_bresp/o_bvalid/i_bready          write response channel
// Out-of-window accesses answer SLVERR; reads then return zero and writes
// leave the array untouched.
// ---------------------------------------------------------------------------
module ysyx_25010008_axil_sram
  import ysyx_25010008_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LATENCY  = 1,
  parameter int          WR_LATENCY  = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [31:0] i_araddr,
  input  logic        i_arvalid,
  output logic        o_arready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rvalid,
  input  logic        i_rready,
  input  logic [31:0] i_awaddr,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wvalid,
  output logic        o_wready,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  axilState_t       r_state, w_nextState;
  logic [31:0]      r_arAddr, r_awAddr, r_wData;
  logic [3:0]       r_wStrb;
  logic             r_gotAw, r_gotW;
  logic [3:0]       r_cnt;
  logic             r_lastWasRead;

  logic             w_wrSel, w_arHs, w_awHs, w_wHs;
  logic             w_rdInRange, w_wrInRange;
  logic [IDX_W-1:0] w_rdIdx, w_wrIdx;
  logic             w_memRe, w_memWe;
  logic [31:0]      w_memRdata;

  // A write wins the idle slot when no read competes, or when the previous
  // transaction was a read; after reset the read gets the first tie.
  assign w_wrSel = i_awvalid && (!i_arvalid || r_lastWasRead);
  assign w_arHs  = o_arready && i_arvalid;
  assign w_awHs  = o_awready && i_awvalid;
  assign w_wHs   = o_wready && i_wvalid;

  assign w_rdInRange = addrInRange(r_arAddr, ADDR_BASE, SPAN_BYTES);
  assign w_wrInRange = addrInRange(r_awAddr, ADDR_BASE, SPAN_BYTES);
  assign w_rdIdx     = IDX_W'((r_arAddr - ADDR_BASE) >> 2);
  assign w_wrIdx     = IDX_W'((r_awAddr - ADDR_BASE) >> 2);

  // State register of the transaction FSM.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake logic. Readies are only ever raised in IDLE or
  // W_COLLECT, so nothing new is accepted while a response is pending. The
  // array read fires on the last wait cycle so its registered output lands
  // exactly as R_RESP is entered; the array write fires on the last W_WAIT
  // cycle and is suppressed for out-of-window addresses.
  always_comb begin
    w_nextState = r_state;
    o_arready   = 1'b0;
    o_awready   = 1'b0;
    o_wready    = 1'b0;
    w_memRe     = 1'b0;
    w_memWe     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wrSel) begin
          o_awready   = 1'b1;
          o_wready    = 1'b1;
          w_nextState = i_wvalid ? ST_W_WAIT : ST_W_COLLECT;
        end else if (i_arvalid) begin
          o_arready   = 1'b1;
          w_nextState = ST_R_WAIT;
        end
      end
      ST_R_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_memRe     = 1'b1;
          w_nextState = ST_R_RESP;
        end
      end
      ST_R_RESP: begin
        if (i_rready) w_nextState = ST_IDLE;
      end
      ST_W_COLLECT: begin
        o_awready = !r_gotAw;
        o_wready  = !r_gotW;
        if ((r_gotAw || w_awHs) && (r_gotW || w_wHs)) w_nextState = ST_W_WAIT;
      end
      ST_W_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_memWe     = w_wrInRange;
          w_nextState = ST_B_RESP;
        end
      end
      ST_B_RESP: begin
        if (i_bready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Request capture, latency counting and the round-robin history bit.
  // The counter is loaded on entry to a wait state and counts down to zero;
  // the got flags remember which write channel has already been taken.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_arAddr      <= '0;
      r_awAddr      <= '0;
      r_wData       <= '0;
      r_wStrb       <= '0;
      r_gotAw       <= 1'b0;
      r_gotW        <= 1'b0;
      r_cnt         <= '0;
      r_lastWasRead <= 1'b0;
    end else begin
      if (w_arHs) begin
        r_arAddr <= i_araddr;
        r_cnt    <= 4'(RD_LATENCY);
      end
      if (w_awHs) begin
        r_awAddr <= i_awaddr;
        r_gotAw  <= 1'b1;
      end
      if (w_wHs) begin
        r_wData <= i_wdata;
        r_wStrb <= i_wstrb;
        r_gotW  <= 1'b1;
      end
      if (w_nextState == ST_W_WAIT && r_state != ST_W_WAIT) begin
        r_cnt <= 4'(WR_LATENCY);
      end
      if ((r_state == ST_R_WAIT || r_state == ST_W_WAIT) && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ST_R_RESP && i_rready) begin
        r_lastWasRead <= 1'b1;
      end
      if (r_state == ST_B_RESP && i_bready) begin
        r_lastWasRead <= 1'b0;
        r_gotAw       <= 1'b0;
        r_gotW        <= 1'b0;
      end
    end
  end

  ysyx_25010008_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .i_clock (i_clock),
    .i_re    (w_memRe),
    .i_raddr (w_rdIdx),
    .o_rdata (w_memRdata),
    .i_we    (w_memWe),
    .i_waddr (w_wrIdx),
    .i_wdata (r_wData),
    .i_wstrb (r_wStrb)
  );

  // Response channels are decoded from the state, so they stay stable for as
  // long as the FSM waits for the matching ready and read zero after reset.
  assign o_rvalid = (r_state == ST_R_RESP);
  assign o_rdata  = (o_rvalid && w_rdInRange) ? w_memRdata : 32'h0;
  assign o_rresp  = (o_rvalid && !w_rdInRange) ? RESP_SLVERR : RESP_OKAY;
  assign o_bvalid = (r_state == ST_B_RESP);
  assign o_bresp  = (o_bvalid && !w_wrInRange) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_ysyx_25010008_axil_sram.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25010008_axil_sram
// Directed bench for the AXI4-Lite SRAM responder: a table of single
// transactions with hand-computed results, then hand-written sequences for
// arbitration, back-pressure, split AW/W arrival and reset mid-write.
// ---------------------------------------------------------------------------
module tb_ysyx_25010008_axil_sram;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 0;

  logic        clock, resetN;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] expData;
    logic [1:0]  expResp;
  } vec_t;

  ysyx_25010008_axil_sram #(
    .ADDR_BASE   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .RD_LATENCY  (RD_LAT),
    .WR_LATENCY  (WR_LAT)
  ) dut (
    .i_clock   (clock),
    .i_reset_n (resetN),
    .i_araddr  (araddr),
    .i_arvalid (arvalid),
    .o_arready (arready),
    .o_rdata   (rdata),
    .o_rresp   (rresp),
    .o_rvalid  (rvalid),
    .i_rready  (rready),
    .i_awaddr  (awaddr),
    .i_awvalid (awvalid),
    .o_awready (awready),
    .i_wdata   (wdata),
    .i_wstrb   (wstrb),
    .i_wvalid  (wvalid),
    .o_wready  (wready),
    .o_bresp   (bresp),
    .o_bvalid  (bvalid),
    .i_bready  (bready)
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a handshake loop ever goes astray.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven there.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    {arvalid, awvalid, wvalid, rready, bready} = '0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    step();
    step();
    #1;
    checkOutput("reset_ctrl", {23'd0, arready, awready, wready, rvalid, bvalid, rresp, bresp}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    resetN = 1'b1;
    step();
  endtask

  // Full read: latency counts rising edges from the AR handshake edge to the
  // first edge after which rvalid is seen.
  task automatic doRead(input logic [31:0] addr, output logic [31:0] data,
                        output logic [1:0] resp, output int lat);
    int n;
    araddr = addr; arvalid = 1'b1; #1;
    n = 0;
    while (!arready && n < 50) begin step(); #1; n++; end
    if (!arready) begin
      checkOutput("arready_timeout", {31'd0, arready}, 32'd1);
      arvalid = 1'b0; data = '0; resp = '0; lat = -1;
      step();
      return;
    end
    @(posedge clock); #1;
    arvalid = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!rvalid && lat < 50);
    data = rdata; resp = rresp;
    rready = 1'b1; step(); rready = 1'b0;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp, output int lat);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; #1;
    n = 0;
    while (!(awready && wready) && n < 50) begin step(); #1; n++; end
    if (!(awready && wready)) begin
      checkOutput("awready_timeout", {31'd0, awready && wready}, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0; resp = '0; lat = -1;
      step();
      return;
    end
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!bvalid && lat < 50);
    resp = bresp;
    bready = 1'b1; step(); bready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] data,
                               output logic [1:0] resp, output int lat);
    if (v.isWrite) begin
      data = '0;
      doWrite(v.addr, v.wdata, v.wstrb, resp, lat);
    end else begin
      doRead(v.addr, data, resp, lat);
    end
  endtask

  initial begin
    vec_t        vecs[17];
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat, nGrant, cyc, stable, sawReady, wreadyCnt;
    int          order[4];
    int          expOrder[4];

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h0000_AB00, 4'h2, 32'h0,         2'b00};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 2'b00};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
    vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[6]  = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
    vecs[8]  = '{1'b1, 32'h8000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'h0,         2'b00};
    vecs[9]  = '{1'b0, 32'h8000_3FFF, 32'h0,         4'h0, 32'hA5A5_A5A5, 2'b00};
    vecs[10] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 2'b00};
    vecs[12] = '{1'b1, 32'h8000_0014, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
    vecs[13] = '{1'b1, 32'h8000_0014, 32'h0099_0000, 4'h4, 32'h0,         2'b00};
    vecs[14] = '{1'b0, 32'h8000_0014, 32'h0,         4'h0, 32'hCA99_F00D, 2'b00};
    vecs[15] = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};

    $display("[TB] start");
    applyReset();

    // Table of single transactions.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i], data, resp, lat);
      if (vecs[i].isWrite) begin
        checkOutput($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].expResp});
        checkOutput($sformatf("vec%0d_wlat", i), lat, WR_LAT + 1);
      end else begin
        checkOutput($sformatf("vec%0d_rdata", i), data, vecs[i].expData);
        checkOutput($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].expResp});
        checkOutput($sformatf("vec%0d_rlat", i), lat, RD_LAT + 1);
      end
    end

    // Read and write requested together, kept up for four grants.
    applyReset();
    araddr = 32'h8000_0010; awaddr = 32'h8000_0020;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    expOrder = '{1, 2, 1, 2};
    order = '{0, 0, 0, 0};
    nGrant = 0; cyc = 0;
    while (nGrant < 4 && cyc < 100) begin
      #1;
      if (arready && arvalid) begin order[nGrant] = 1; nGrant++; end
      else if (awready && awvalid) begin order[nGrant] = 2; nGrant++; end
      step();
      cyc++;
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (6) step();
    rready = 1'b0; bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("arb_order%0d", i), order[i], expOrder[i]);
    end
    doRead(32'h8000_0020, data, resp, lat);
    checkOutput("arb_write_data", data, 32'h0BAD_F00D);

    // Back-pressure on R with a competing read request held up.
    araddr = 32'h8000_0014; arvalid = 1'b1; #1;
    cyc = 0;
    while (!arready && cyc < 50) begin step(); #1; cyc++; end
    @(posedge clock); #1;
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 50) begin step(); cyc++; end
    araddr = 32'h8000_0010; arvalid = 1'b1;
    stable = 0; sawReady = 0;
    repeat (5) begin
      #1;
      if (rvalid === 1'b1 && rdata === 32'hCA99_F00D && rresp === 2'b00) stable++;
      if (arready) sawReady = 1;
      step();
    end
    arvalid = 1'b0;
    checkOutput("stall_stable_cycles", stable, 5);
    checkOutput("stall_no_arready", sawReady, 0);
    rready = 1'b1; step(); rready = 1'b0;
    #1;
    checkOutput("stall_rvalid_released", {31'd0, rvalid}, 32'd0);
    step();

    // W arrives three cycles ahead of AW.
    awaddr = 32'h8000_0030; wdata = 32'h1357_9BDF; wstrb = 4'hF;
    wvalid = 1'b1; wreadyCnt = 0;
    repeat (3) begin #1; if (wready) wreadyCnt++; step(); end
    awvalid = 1'b1; #1;
    checkOutput("early_awready", {31'd0, awready}, 32'd1);
    if (wready) wreadyCnt++;
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b0; #1;
    if (wready) wreadyCnt++;
    checkOutput("early_wready_pulses", wreadyCnt, 1);
    checkOutput("early_bvalid_not_yet", {31'd0, bvalid}, 32'd0);
    step();
    checkOutput("early_bvalid", {31'd0, bvalid}, 32'd1);
    checkOutput("early_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1; step(); bready = 1'b0;
    doRead(32'h8000_0030, data, resp, lat);
    checkOutput("early_readback", data, 32'h1357_9BDF);

    // AW arrives alone: only the W channel stays open.
    awaddr = 32'h8000_0034; wdata = 32'h2468_ACE0; wstrb = 4'hF;
    awvalid = 1'b1; #1;
    checkOutput("collect_aw_accept", {31'd0, awready}, 32'd1);
    @(posedge clock); #1;
    awvalid = 1'b0; #1;
    checkOutput("collect_awready", {31'd0, awready}, 32'd0);
    checkOutput("collect_wready", {31'd0, wready}, 32'd1);
    step();
    wvalid = 1'b1;
    @(posedge clock); #1;
    wvalid = 1'b0;
    checkOutput("collect_bvalid_not_yet", {31'd0, bvalid}, 32'd0);
    step();
    checkOutput("collect_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1; step(); bready = 1'b0;
    doRead(32'h8000_0034, data, resp, lat);
    checkOutput("collect_readback", data, 32'h2468_ACE0);

    // Repeat of the early-W write, abandoned by reset while in W_WAIT.
    awaddr = 32'h8000_0030; wdata = 32'hFFFF_0000; wstrb = 4'hF;
    wvalid = 1'b1;
    repeat (3) step();
    awvalid = 1'b1;
    @(posedge clock); #1;
    resetN = 1'b0; awvalid = 1'b0; wvalid = 1'b0; #1;
    checkOutput("wwait_reset_ctrl", {23'd0, arready, awready, wready, rvalid, bvalid, rresp, bresp}, 32'd0);
    checkOutput("wwait_reset_rdata", rdata, 32'd0);
    step();
    step();
    resetN = 1'b1;
    step();
    checkOutput("wwait_reset_bvalid", {31'd0, bvalid}, 32'd0);
    doRead(32'h8000_0030, data, resp, lat);
    checkOutput("wwait_reset_unchanged", data, 32'h1357_9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
